// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Holds the FSM state encoding, the bit-period calculation and counter-width helpers.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    localparam int N_REQ_DEFAULT = 4;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Keeps counters at least one bit wide when the count is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first valid requester at or above rr_ptr, wrapping.
// Returns the pick as both a one-hot vector and an index.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    localparam int IW = cnt_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IW-1:0]    grant_idx,
    output logic             any_valid
);

    logic [IW-1:0] idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % N_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid      = 1'b1;
                grant_oh[idx]  = 1'b1;
                grant_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-granular round-robin scheduler in front of a single UART byte transmitter.
// A granted requester keeps the transmitter until its last byte plus a full stop-bit gap.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no owner; arbitrate among valid requesters
// LOAD      | req_ready = grant; wait for the owner's next byte (timed out)
// START     | one-cycle tx_start pulse to the transmitter
// WAIT_DONE | frame in flight; wait for tx_done (start of stop bit)
// GAP       | hold off BIT_CYC cycles so the stop bit is a full bit period
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEFAULT,
    parameter int CLK         = 50000000,
    parameter int BAUD        = 115200,
    parameter int PKT_TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_done,
    output logic               busy,
    output logic               err_timeout
);

    localparam int BIT_CYC = bit_cycles(CLK, BAUD);
    localparam int IW      = cnt_width(N_REQ);
    localparam int GW      = cnt_width(BIT_CYC);
    localparam int TW      = cnt_width(PKT_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(BIT_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(PKT_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [IW-1:0]     rr_ptr, g_idx, arb_idx, next_ptr;
    logic [N_REQ-1:0]  arb_oh;
    logic              arb_any;
    logic [GW-1:0]     gap_cnt;
    logic [TW-1:0]     to_cnt;
    logic              last_q;
    logic              hs;
    logic [7:0]        sel_data;
    logic              sel_last;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    assign next_ptr = (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + IW'(1);
    assign sel_data = req_data[8*g_idx +: 8];
    assign sel_last = req_last[g_idx];
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        tx_start    = 1'b0;
        err_timeout = 1'b0;
        hs          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                req_ready = grant;
                hs        = |(req_valid & grant);
                if (hs) begin
                    state_nxt = ST_START;
                end else if (to_cnt == TO_LAST) begin
                    err_timeout = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_START: begin
                tx_start  = 1'b1;
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = last_q ? ST_IDLE : ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // tx_data only moves on a LOAD handshake; the transmitter re-samples it every bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant   <= '0;
            g_idx   <= '0;
            rr_ptr  <= '0;
            tx_data <= 8'h00;
            last_q  <= 1'b0;
            gap_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant <= arb_oh;
                        g_idx <= arb_idx;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        tx_data <= sel_data;
                        last_q  <= sel_last;
                        to_cnt  <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_WAIT_DONE: gap_cnt <= '0;
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (last_q) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with a behavioural UART byte transmitter and serial decoder.
// Requester byte sources and expected frames live in queues; frames are checked as they finish.
module tb_uart_tx_sched;

    localparam int N       = 4;
    localparam int BIT_CYC = 10;
    localparam int TMO     = 40;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready, grant;
    logic [7:0]     tx_data;
    logic           tx_start, busy, err_timeout;
    logic           tx_done = 1'b0;

    always #5 clk = ~clk;

    uart_tx_sched #(.N_REQ(N), .CLK(1000), .BAUD(100), .PKT_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    typedef struct packed {
        logic [1:0] who;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int         who;
        logic [7:0] data;
        logic [N-1:0] exp_grant;
        logic [1:0] exp_ptr;
    } vec_t;

    exp_t       exp_q[$];
    logic [8:0] src_q[N][$];
    int total = 0;
    int bad   = 0;

    // transmitter model / monitor state
    int         cyc = 0;
    bit         u_busy = 0;
    int         u_bit = 0, u_cnt = 0;
    logic       uart_line = 1'b1;
    logic [7:0] frame_byte = '0, rx_byte = '0;
    bit         have_done = 0;
    int         done_cyc = 0;
    int         stray = 0;
    int         err_cnt = 0;
    int         load_run = 0;
    logic       prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit src_pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_byte(input int who, input logic [7:0] d, input logic last);
        exp_t e;
        src_q[who].push_back({last, d});
        e.who  = 2'(who);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || src_pending() || exp_q.size() != 0) && n < 5000) begin
            @(posedge clk); #2;
            n++;
        end
        check({name, "_idle"}, 32'(n < 5000), 1);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!tx_start && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        check({name, "_start_seen"}, 32'(tx_start), 1);
    endtask

    // Requester sources plus UART transmitter model; all samples are pre-edge values.
    always begin
        logic [N-1:0] hs_s, g_s, rr_s;
        logic         ts_s, er_s;
        logic [7:0]   td_s;
        logic [8:0]   nb;
        logic [N-1:0] eg;
        exp_t         e;
        @(posedge clk);
        hs_s = req_valid & req_ready;
        ts_s = tx_start;
        td_s = tx_data;
        g_s  = grant;
        er_s = err_timeout;
        rr_s = req_ready;
        #1;
        cyc++;
        if (!rstn) begin
            u_busy     = 0;
            uart_line  = 1'b1;
            tx_done    = 1'b0;
            prev_start = 1'b0;
            have_done  = 0;
            load_run   = 0;
        end else begin
            tx_done = 1'b0;
            for (int i = 0; i < N; i++)
                if (hs_s[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            if (ts_s && (u_busy || prev_start)) stray++;
            prev_start = ts_s;
            if (er_s) begin
                err_cnt++;
                check("timeout_len", 32'(load_run + 1), TMO);
                check("grant_after_timeout", 32'(grant), 0);
                load_run = 0;
            end else if (rr_s != '0 && hs_s == '0) begin
                load_run++;
            end else begin
                load_run = 0;
            end
            if (u_busy) begin
                if (td_s !== frame_byte) stray++;
                u_cnt++;
                if (u_cnt == BIT_CYC) begin
                    u_cnt = 0;
                    u_bit++;
                    if (u_bit <= 8) begin
                        uart_line = td_s[u_bit-1];
                    end else begin
                        uart_line = 1'b1;
                        tx_done   = 1'b1;
                        u_busy    = 0;
                        have_done = 1;
                        done_cyc  = cyc;
                        check("sb_has_expected", 32'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e  = exp_q.pop_front();
                            eg = '0;
                            eg[e.who] = 1'b1;
                            check("sb_byte", 32'(rx_byte), 32'(e.data));
                            check("sb_owner", 32'(g_s), 32'(eg));
                        end
                    end
                end else if (u_cnt == BIT_CYC/2 && u_bit >= 1) begin
                    rx_byte[u_bit-1] = uart_line;
                end
            end else if (ts_s) begin
                if (have_done) check("stop_len_min", 32'((cyc - done_cyc) >= BIT_CYC), 1);
                u_busy     = 1;
                u_bit      = 0;
                u_cnt      = 0;
                uart_line  = 1'b0;
                frame_byte = td_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) begin
                nb = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = nb[7:0];
                req_last[i]        = nb[8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    initial begin
        vec_t vecs[4];
        int   remaining, who, len;
        vecs[0] = '{2, 8'h3C, 4'b0100, 2'd3};
        vecs[1] = '{0, 8'hE7, 4'b0001, 2'd1};
        vecs[2] = '{3, 8'h81, 4'b1000, 2'd0};
        vecs[3] = '{1, 8'h5A, 4'b0010, 2'd2};

        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_grant", 32'(grant), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_rr_ptr", 32'(dut.rr_ptr), 0);
        @(negedge clk) rstn = 1'b1;

        // simultaneous requesters 1 and 2 with rr_ptr at 0
        @(posedge clk); #2;
        push_byte(1, 8'hA1, 1'b0);
        push_byte(1, 8'hB1, 1'b1);
        push_byte(2, 8'hC2, 1'b1);
        wait_idle("arb");
        check("arb_rr_ptr", 32'(dut.rr_ptr), 3);

        // two-byte packet from requester 0
        @(posedge clk); #2;
        push_byte(0, 8'h55, 1'b0);
        push_byte(0, 8'hA3, 1'b1);
        wait_idle("two_byte");
        check("two_byte_grant_clear", 32'(grant), 0);
        check("two_byte_rr_ptr", 32'(dut.rr_ptr), 1);

        // requester 3 arrives mid-packet and must wait for requester 0's last byte
        @(posedge clk); #2;
        push_byte(0, 8'h10, 1'b0);
        push_byte(0, 8'h20, 1'b0);
        push_byte(0, 8'h30, 1'b1);
        wait_start("mid");
        push_byte(3, 8'h44, 1'b1);
        wait_idle("mid");
        check("mid_rr_ptr", 32'(dut.rr_ptr), 0);

        // requester 0 stalls after its first byte; requester 1 is served after the abort
        @(posedge clk); #2;
        push_byte(0, 8'h11, 1'b0);
        wait_start("tmo");
        push_byte(1, 8'h22, 1'b1);
        wait_idle("tmo");
        check("tmo_err_count", 32'(err_cnt), 1);
        check("tmo_rr_ptr", 32'(dut.rr_ptr), 2);

        // single-byte latency vectors
        for (int v = 0; v < 4; v++) begin
            wait_idle("vec_pre");
            @(posedge clk); #2;
            push_byte(vecs[v].who, vecs[v].data, 1'b1);
            @(posedge clk); #2;
            check("vec_c0_busy", 32'(busy), 0);
            @(posedge clk); #2;
            check("vec_c1_grant", 32'(grant), 32'(vecs[v].exp_grant));
            check("vec_c1_ready", 32'(req_ready), 32'(vecs[v].exp_grant));
            @(posedge clk); #2;
            check("vec_c2_start", 32'(tx_start), 1);
            wait_idle("vec");
            check("vec_rr_ptr", 32'(dut.rr_ptr), 32'(vecs[v].exp_ptr));
        end

        // asynchronous reset during the data bits of a frame
        @(posedge clk); #2;
        push_byte(2, 8'hC5, 1'b0);
        push_byte(2, 8'h6B, 1'b1);
        wait_start("rst_mid");
        repeat (4*BIT_CYC) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_tx_start", 32'(tx_start), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err", 32'(err_timeout), 0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #2;
        push_byte(1, 8'h9E, 1'b1);
        wait_idle("post_rst");

        // 100 random bytes in random-length packets from random requesters
        remaining = 100;
        while (remaining > 0) begin
            who = $urandom_range(0, N-1);
            len = $urandom_range(1, 4);
            if (len > remaining) len = remaining;
            @(posedge clk); #2;
            for (int b = 0; b < len; b++)
                push_byte(who, 8'($urandom_range(0, 255)), 1'(b == len - 1));
            wait_idle("rand");
            remaining -= len;
        end

        check("no_stray_start_or_data_change", 32'(stray), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
